// File: rtl/quad_dec_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI RAM sequencer.
// Optional feature macro: QUAD_DEC_OCIMEM_BOUNDS_EN (see top).
package quad_dec_ocimem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_J_ACC,
    S_J_RD,
    S_C_ACC,
    S_C_RD
  } state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } grant_e;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RDNOW_BIT = 35;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  localparam int REQ_CPU  = 0;
  localparam int REQ_JTAG = 1;

endpackage

// File: rtl/quad_dec_ocimem_rr_arb.sv
// Two-way round-robin arbiter between CPU (req[0]) and JTAG (req[1]).
// A tie goes to the requester that was not granted last.
module quad_dec_ocimem_rr_arb
  import quad_dec_ocimem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt
);

  grant_e last_grant;
  grant_e gnt_e;

  always_comb begin
    gnt_e = (last_grant == GNT_CPU) ? GNT_JTAG : GNT_CPU;
    unique case (1'b1)
      (req == 2'b01): gnt_e = GNT_CPU;
      (req == 2'b10): gnt_e = GNT_JTAG;
      default: ;
    endcase
  end

  assign gnt = gnt_e;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GNT_CPU;
    end else if (advance) begin
      last_grant <= gnt_e;
    end
  end

endmodule

// File: rtl/quad_dec_cpu_ocimem_sequencer.sv
// Sysclk-side OCI RAM controller: JTAG strobes and CPU Avalon slave share one RAM.
// Define QUAD_DEC_OCIMEM_BOUNDS_EN to reject accesses at or beyond RAM_DEPTH.
module quad_dec_cpu_ocimem_sequencer
  import quad_dec_ocimem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] jtag_addr;
  logic [DATA_W-1:0] jtag_wdata;
  logic              jtag_pend, jtag_wr, load_ack;
  logic              cpu_pend;
  logic              strobe, accept, rd_now;
  logic              jtag_done, jtag_oob, cpu_done;
  logic              advance, gnt;
  logic              j_ok, c_ok;
  logic              unused_jdo;

  assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

`ifdef QUAD_DEC_OCIMEM_BOUNDS_EN
  assign j_ok = 32'(jtag_addr) < 32'(RAM_DEPTH);
  assign c_ok = 32'(av_address) < 32'(RAM_DEPTH);
`else
  assign j_ok = 1'b1;
  assign c_ok = 1'b1;
`endif

  assign strobe = take_action_ocimem_a | take_action_ocimem_b
                | take_no_action_ocimem_a;
  // A strobe landing on the completion cycle sees the slot as free.
  assign accept = strobe & (~jtag_pend | jtag_done);
  assign rd_now = jdo[JDO_RDNOW_BIT];

  quad_dec_ocimem_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({jtag_pend, cpu_pend}),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_nx       = state;
    ram_addr       = '0;
    ram_wdata      = '0;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    av_waitrequest = 1'b1;
    av_readdata    = '0;
    jtag_done      = 1'b0;
    jtag_oob       = 1'b0;
    cpu_done       = 1'b0;
    advance        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (jtag_pend | cpu_pend) begin
          advance  = 1'b1;
          state_nx = (gnt == GNT_JTAG) ? S_J_ACC : S_C_ACC;
        end
      end
      S_J_ACC: begin
        ram_addr = jtag_addr;
        if (!j_ok) begin
          jtag_done = 1'b1;
          jtag_oob  = 1'b1;
          state_nx  = S_IDLE;
        end else if (jtag_wr) begin
          ram_we    = 1'b1;
          ram_wdata = jtag_wdata;
          jtag_done = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          ram_re   = 1'b1;
          state_nx = S_J_RD;
        end
      end
      S_J_RD: begin
        jtag_done = 1'b1;
        state_nx  = S_IDLE;
      end
      S_C_ACC: begin
        ram_addr = av_address;
        if (av_write) begin
          ram_we         = c_ok;
          ram_wdata      = av_writedata;
          av_waitrequest = 1'b0;
          cpu_done       = 1'b1;
          state_nx       = S_IDLE;
        end else begin
          ram_re   = c_ok;
          state_nx = S_C_RD;
        end
      end
      S_C_RD: begin
        av_waitrequest = 1'b0;
        av_readdata    = c_ok ? ram_rdata : '0;
        cpu_done       = 1'b1;
        state_nx       = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      jtag_addr     <= '0;
      jtag_wdata    <= '0;
      jtag_pend     <= 1'b0;
      jtag_wr       <= 1'b0;
      load_ack      <= 1'b0;
      cpu_pend      <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      state    <= state_nx;
      load_ack <= 1'b0;
      if (cpu_done) begin
        cpu_pend <= 1'b0;
      end else if (av_read | av_write) begin
        cpu_pend <= 1'b1;
      end
      if (state == S_J_RD) begin
        MonDReg <= ram_rdata;
      end
      if (jtag_done) begin
        jtag_pend     <= 1'b0;
        monitor_ready <= 1'b1;
        if (jtag_oob) begin
          monitor_error <= 1'b1;
        end else begin
          jtag_addr <= jtag_addr + 1'b1;
        end
      end
      if (load_ack) begin
        monitor_ready <= 1'b1;
      end
      if (accept) begin
        monitor_ready <= 1'b0;
        jtag_wr       <= take_action_ocimem_b;
        if (take_action_ocimem_a) begin
          jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
        end
        if (take_action_ocimem_b) begin
          jtag_wdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        end
        if (take_action_ocimem_a & ~rd_now) begin
          load_ack <= 1'b1;
        end else begin
          jtag_pend <= 1'b1;
        end
      end else if (strobe) begin
        monitor_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_dec_cpu_ocimem_sequencer.sv
// Scoreboard bench: random JTAG/CPU traffic against a memory model,
// plus arbitration, overrun, reset and range scenarios.
module tb_quad_dec_cpu_ocimem_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
  logic [7:0]  av_address = '0;
  logic        av_read = 1'b0, av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  always #5 clk = ~clk;

  quad_dec_cpu_ocimem_sequencer #(
    .ADDR_W(8), .DATA_W(32), .RAM_DEPTH(200)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  logic [31:0] tb_ram [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (ram_we) tb_ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= tb_ram[ram_addr];
  end

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       jw_q[$], cw_q[$], jr_q[$], cr_q[$];
  logic [7:0] re_log[$];
  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0, strobe_cyc = 0, last_we_cyc = 0, last_re_cyc = 0;
  logic       prev_ready = 1'b0;
  logic [7:0] jaddr_m = '0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT shows an output event.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (ram_we || ram_re) check("we_re_excl", ram_we & ram_re, 0);
      if (ram_re) begin
        re_log.push_back(ram_addr);
        last_re_cyc <= cyc;
      end
      if (ram_we) begin
        last_we_cyc <= cyc;
        if (ram_addr < 8'h80) begin
          check("jtag_wr_expected", jw_q.size() != 0, 1);
          if (jw_q.size() != 0) begin
            e = jw_q.pop_front();
            check("jtag_wr_addr", ram_addr, e.addr);
            check("jtag_wr_data", ram_wdata, e.data);
          end
        end else begin
          check("cpu_wr_expected", cw_q.size() != 0, 1);
          if (cw_q.size() != 0) begin
            e = cw_q.pop_front();
            check("cpu_wr_addr", ram_addr, e.addr);
            check("cpu_wr_data", ram_wdata, e.data);
          end
        end
      end
      if (!av_waitrequest && av_read) begin
        check("cpu_rd_expected", cr_q.size() != 0, 1);
        if (cr_q.size() != 0) begin
          e = cr_q.pop_front();
          check("cpu_rd_data", av_readdata, e.data);
        end
      end
      if (monitor_ready && !prev_ready) begin
        check("jtag_done_expected", jr_q.size() != 0, 1);
        if (jr_q.size() != 0) begin
          e = jr_q.pop_front();
          if (e.kind == 2) check("jtag_mondreg", MonDReg, e.data);
        end
      end
    end
    prev_ready <= monitor_ready;
  end

  task automatic jtag_strobe(input int kind, input logic [7:0] a,
                             input bit rd, input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[24:17] = a;
    v[35] = rd;
    if (kind == 1) v[34:3] = d;
    @(posedge clk) #1;
    strobe_cyc = cyc;
    jdo = v;
    ta_a = (kind == 0);
    ta_b = (kind == 1);
    tna_a = (kind == 2);
    @(posedge clk) #1;
    ta_a = 0; ta_b = 0; tna_a = 0;
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (monitor_ready) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic j_load(input logic [7:0] a, input bit rd);
    jaddr_m = a;
    if (rd) begin
`ifdef QUAD_DEC_OCIMEM_BOUNDS_EN
      if (a >= 8'd200) jr_q.push_back('{0, a, 0});
      else begin
        jr_q.push_back('{2, a, ref_mem[a]});
        jaddr_m = a + 1;
      end
`else
      jr_q.push_back('{2, a, ref_mem[a]});
      jaddr_m = a + 1;
`endif
    end else begin
      jr_q.push_back('{0, a, 0});
    end
    jtag_strobe(0, a, rd, 0);
    wait_ready("jtag_load_timeout");
  endtask

  task automatic j_write(input logic [31:0] d);
    jw_q.push_back('{1, jaddr_m, d});
    jr_q.push_back('{1, jaddr_m, d});
    ref_mem[jaddr_m] = d;
    jaddr_m = jaddr_m + 1;
    jtag_strobe(1, 0, 0, d);
    wait_ready("jtag_write_timeout");
  endtask

  task automatic j_read();
    jr_q.push_back('{2, jaddr_m, ref_mem[jaddr_m]});
    jaddr_m = jaddr_m + 1;
    jtag_strobe(2, 0, 0, 0);
    wait_ready("jtag_read_timeout");
  endtask

  task automatic c_op(input bit wr, input logic [7:0] a,
                      input logic [31:0] d);
    bit ok;
    if (wr) begin
      cw_q.push_back('{1, a, d});
      ref_mem[a] = d;
    end else begin
      cr_q.push_back('{2, a, ref_mem[a]});
    end
    @(posedge clk) #1;
    av_address = a;
    av_read = !wr;
    av_write = wr;
    av_writedata = d;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!av_waitrequest) begin
        ok = 1;
        break;
      end
    end
    check("cpu_timeout", ok, 1);
    @(posedge clk) #1;
    av_read = 0;
    av_write = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_av_readdata"}, av_readdata, 0);
    check({tag, "_av_waitrequest"}, av_waitrequest, 1);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_re"}, ram_re, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_mondreg"}, MonDReg, 0);
    check({tag, "_ready"}, monitor_ready, 0);
    check({tag, "_error"}, monitor_error, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) begin
      tb_ram[i] = $urandom;
      ref_mem[i] = tb_ram[i];
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk) #1;
    reset_n = 1;

    // Arbitration with last grant = CPU: JTAG first.
    j_load(8'h50, 0);
    re_log.delete();
    fork
      j_read();
      c_op(0, 8'h90, 0);
    join
    check("arb1_count", re_log.size(), 2);
    if (re_log.size() >= 2) begin
      check("arb1_first", re_log[0], 8'h50);
      check("arb1_second", re_log[1], 8'h90);
    end

    // Write via ocimem_b after an address load; ram_we 2 cycles on.
    j_load(8'h10, 0);
    j_write(32'hDEADBEEF);
    check("wr_latency", last_we_cyc - strobe_cyc, 2);
    check("ready_after_wr", monitor_ready, 1);

    // Last grant now JTAG: CPU wins the tie.
    re_log.delete();
    fork
      j_read();
      c_op(0, 8'hA0, 0);
    join
    check("arb2_count", re_log.size(), 2);
    if (re_log.size() >= 2) begin
      check("arb2_first", re_log[0], 8'hA0);
      check("arb2_second", re_log[1], 8'h11);
    end

    // Read-now load returns the written word.
    j_load(8'h10, 1);
    check("rd_latency", last_re_cyc - strobe_cyc, 2);
    check("mondreg_deadbeef", MonDReg, 32'hDEADBEEF);

    // Random concurrent traffic on disjoint halves of the RAM.
    fork
      for (int n = 0; n < 30; n++) begin
        int r;
        r = $urandom_range(0, 3);
        if (r == 0 || jaddr_m >= 8'h7E)
          j_load(8'($urandom_range(0, 8'h70)), 1'($urandom_range(0, 1)));
        else if (r == 1) j_write($urandom);
        else j_read();
      end
      for (int n = 0; n < 30; n++) begin
        c_op(1'($urandom_range(0, 1)),
             8'h80 + 8'($urandom_range(0, 8'h7F)), $urandom);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    join
    check("rand_no_error", monitor_error, 0);

    // 0xF0 lies past RAM_DEPTH=200.
    re_log.delete();
    j_load(8'hF0, 1);
`ifdef QUAD_DEC_OCIMEM_BOUNDS_EN
    check("bounds_no_re", re_log.size(), 0);
    check("bounds_error", monitor_error, 1);
`else
    check("nobounds_re_count", re_log.size(), 1);
    if (re_log.size() != 0) check("nobounds_re_addr", re_log[0], 8'hF0);
    check("nobounds_no_error", monitor_error, 0);
`endif
    check("bounds_ready", monitor_ready, 1);

    // Overrun: second ocimem_b one cycle after the first is dropped.
    j_load(8'h40, 0);
    jw_q.push_back('{1, 8'h40, 32'h11112222});
    jr_q.push_back('{1, 8'h40, 32'h11112222});
    ref_mem[8'h40] = 32'h11112222;
    @(posedge clk) #1;
    jdo = '0;
    jdo[34:3] = 32'h11112222;
    ta_b = 1;
    @(posedge clk) #1;
    jdo[34:3] = 32'h33334444;
    @(posedge clk) #1;
    ta_b = 0;
    wait_ready("overrun_timeout");
    check("overrun_error", monitor_error, 1);
    j_load(8'h40, 1);
    j_read();
    check("overrun_error_sticky", monitor_error, 1);

    // Reset while J_ACC drives a write.
    j_load(8'h30, 0);
    jw_q.push_back('{1, 8'h30, 32'h12345678});
    seen = 0;
    fork
      jtag_strobe(1, 0, 0, 32'h12345678);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ram_we) begin
          seen = 1;
          break;
        end
      end
    join
    check("rst_we_seen", seen, 1);
    #2 reset_n = 0;
    #1 check("rst_we_drop", ram_we, 0);
    jr_q.delete();
    jw_q.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs("midop_reset");
    @(posedge clk) #1;
    reset_n = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_release");
    jaddr_m = 0;
    re_log.delete();
    j_read();
    check("post_rst_addr_count", re_log.size(), 1);
    if (re_log.size() != 0) check("post_rst_addr", re_log[0], 0);
    j_load(8'h30, 1);

    repeat (4) @(negedge clk);
    check("jw_q_empty", jw_q.size(), 0);
    check("cw_q_empty", cw_q.size(), 0);
    check("jr_q_empty", jr_q.size(), 0);
    check("cr_q_empty", cr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
